// File: rtl/bmult_pkg.sv
// bmult_pkg: shared widths, operand/product types and the in-flight tag record
// Used by bmult_share_ctrl and rr_arbiter. ID_W covers up to 8 requesters.
package bmult_pkg;
  localparam int OP_W = 28;
  localparam int P_W  = 56;
  localparam int ID_W = 3;
  typedef logic [OP_W-1:0] op_t;
  typedef logic [P_W-1:0]  prod_t;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/bmult_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with an internal last-grant pointer
// Ports: clk, rst_n (async, active-low); req (requests); advance (commit the
// current grant to the pointer); gnt (one-hot or zero, combinational).
module rr_arbiter
  import bmult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic          w_found;
  // Search starts one past the last winner and wraps, so each requester
  // gets its turn before the same one wins twice.
  always_comb begin
    logic [IW-1:0] j;
    gnt     = '0;
    w_idx   = r_last;
    w_found = 1'b0;
    j       = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(r_last) + k) % N);
      if (!w_found && req[j]) begin
        gnt[j]  = 1'b1;
        w_idx   = j;
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= IW'(N - 1);
    else if (advance) r_last <= w_idx;
  end
endmodule

// File: rtl/bmult_share_ctrl.sv
// bmult_share_ctrl: time-shares one pipelined 28x28 multiplier among NREQ requesters
// Ports: clk, rst_n (async, active-low); req_valid/req_ready/req_a/req_b request
// side; rsp_valid/rsp_ready/rsp_p per-requester result side; mult_a/mult_b/mult_p
// to/from the multiplier beside this block; ops_issued wrapping handshake count.
module bmult_share_ctrl
  import bmult_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  op_t  [NREQ-1:0]     req_a,
  input  op_t  [NREQ-1:0]     req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output prod_t [NREQ-1:0]    rsp_p,
  output op_t                 mult_a,
  output op_t                 mult_b,
  input  prod_t               mult_p,
  output logic [CNT_W-1:0]    ops_issued
);
  logic [NREQ-1:0]  r_busy;
  logic [NREQ-1:0]  r_rsp_valid;
  prod_t [NREQ-1:0] r_rsp_p;
  tag_t             r_tag [MULT_LAT];
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic             w_any;
  logic [ID_W-1:0]  w_gid;
  op_t              w_a;
  op_t              w_b;
  tag_t             w_last;
  // A busy requester already owns an operation in flight or a held result,
  // which is what keeps its single result register from being overwritten.
  assign w_elig = req_valid & ~r_busy;
  assign w_any  = |w_gnt;
  assign w_last = r_tag[MULT_LAT-1];
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_elig),
    .advance (w_any),
    .gnt     (w_gnt)
  );
  always_comb begin
    w_gid = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gid = ID_W'(i);
        w_a   = req_a[i];
        w_b   = req_b[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MULT_LAT; s++) r_tag[s] <= '0;
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_p     <= '0;
      r_cnt       <= '0;
    end else begin
      r_tag[0] <= {w_any, w_gid};
      for (int s = 1; s < MULT_LAT; s++) r_tag[s] <= r_tag[s-1];
      r_cnt <= r_cnt + CNT_W'(w_any);
      // Capture and rsp handshake for the same id never coincide: the owner
      // stays busy until its result is taken, so it cannot have a second tag.
      for (int i = 0; i < NREQ; i++) begin
        if (w_last.valid && w_last.id == ID_W'(i)) begin
          r_rsp_p[i]     <= mult_p;
          r_rsp_valid[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
        if (w_gnt[i]) r_busy[i] <= 1'b1;
        else if (r_rsp_valid[i] && rsp_ready[i]) r_busy[i] <= 1'b0;
      end
    end
  end
  assign req_ready  = w_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_p      = r_rsp_p;
  assign mult_a     = w_a;
  assign mult_b     = w_b;
  assign ops_issued = r_cnt;
endmodule

// File: tb/tb_bmult_share_ctrl.sv
// tb_bmult_share_ctrl: randomized and directed checks of bmult_share_ctrl against a
// transaction-level model (per-requester owner state, due cycle and product).
module tb_bmult_share_ctrl;
  import bmult_pkg::*;
  localparam int N   = 4;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, rsp_ready, req_ready, rsp_valid, req_ready4, rsp_valid4;
  op_t  [N-1:0] req_a, req_b;
  prod_t [N-1:0] rsp_p, rsp_p4;
  op_t   mult_a, mult_b, mult_a4, mult_b4;
  prod_t mult_p;
  prod_t mp [LAT];
  logic [31:0] ops;
  logic [3:0]  ops4;
  bmult_share_ctrl #(.NREQ(N), .MULT_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .ops_issued(ops)
  );
  bmult_share_ctrl #(.NREQ(N), .MULT_LAT(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p4), .mult_a(mult_a4), .mult_b(mult_b4), .mult_p(mult_p),
    .ops_issued(ops4)
  );
  // Pipelined multiplier beside the controller; never reset, so stale products drain.
  always @(posedge clk) begin
    mp[0] <= prod_t'(mult_a) * prod_t'(mult_b);
    for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
  end
  assign mult_p = mp[LAT-1];
  logic [N-1:0] m_busy;
  int           m_due [N];
  prod_t        m_p [N];
  int           m_last;
  logic [31:0]  m_cnt;
  int           cyc;
  int           n_chk = 0;
  int           n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask
  function automatic op_t rnd_op();
    int c;
    c = int'($urandom_range(0, 5));
    if (c == 0) return '0;
    if (c == 1) return '1;
    return op_t'($urandom);
  endfunction
  task automatic step();
    int g;
    logic [N-1:0] ev, eg;
    #1;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
    end
    eg = (g < 0) ? '0 : (N'(1) << g);
    for (int i = 0; i < N; i++) ev[i] = m_busy[i] && (cyc >= m_due[i]);
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("req_ready_w4", 64'(req_ready4), 64'(eg));
    chk("mult_a", 64'(mult_a), (g < 0) ? 64'd0 : 64'(req_a[g]));
    chk("mult_b", 64'(mult_b), (g < 0) ? 64'd0 : 64'(req_b[g]));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    for (int i = 0; i < N; i++) if (ev[i]) chk("rsp_p", 64'(rsp_p[i]), 64'(m_p[i]));
    chk("ops_issued", 64'(ops), 64'(m_cnt));
    chk("ops_issued_w4", 64'(ops4), 64'(m_cnt[3:0]));
    for (int i = 0; i < N; i++) if (ev[i] && rsp_ready[i]) m_busy[i] = 1'b0;
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_due[g]  = cyc + LAT + 1;
      m_p[g]    = prod_t'(req_a[g]) * prod_t'(req_b[g]);
      m_last    = g;
      m_cnt     = m_cnt + 1;
    end
    cyc++;
  endtask
  task automatic tick(input logic [N-1:0] v, input logic [N-1:0] r, input bit rnd);
    @(negedge clk);
    req_valid = v;
    rsp_ready = r;
    if (rnd) for (int i = 0; i < N; i++) begin
      req_a[i] = rnd_op();
      req_b[i] = rnd_op();
    end
    step();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ops", 64'(ops), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mult_a", 64'(mult_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = '0;
    m_last = N - 1;
    m_cnt  = '0;
    cyc    = 0;
  endtask
  initial begin
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    m_busy = '0;
    m_last = N - 1;
    m_cnt = '0;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_due[i] = 0;
      m_p[i] = '0;
    end
    do_reset();
    req_a[0] = 28'd3;
    req_b[0] = 28'd5;
    tick(4'b0001, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0001, 1'b0);
    chk("single_valid", 64'(rsp_valid[0]), 64'd1);
    chk("single_p", 64'(rsp_p[0]), 64'd15);
    chk("single_cnt", 64'(ops), 64'd1);
    req_a[1] = 28'hFFFFFFF;
    req_b[1] = 28'hFFFFFFF;
    tick(4'b0010, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0010, 1'b0);
    chk("max_p", 64'(rsp_p[1]), 64'h00FF_FFFF_E000_0001);
    req_a[2] = 28'd0;
    req_b[2] = 28'hFFFFFFF;
    tick(4'b0100, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0100, 1'b0);
    chk("zero_p", 64'(rsp_p[2]), 64'd0);
    do_reset();
    for (int k = 0; k < N; k++) begin
      tick('1, '1, 1'b1);
      chk("rr_order", 64'(req_ready), 64'(1) << k);
    end
    for (int k = 0; k < 60 && m_cnt != 32'd17; k++) tick('1, '1, 1'b1);
    chk("wrap_reached", 64'(m_cnt), 64'd17);
    tick('0, '1, 1'b1);
    chk("wrap17_w4", 64'(ops4), 64'd1);
    do_reset();
    for (int k = 0; k < 8; k++) tick('1, '1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick('1, 4'b1101, 1'b1);
      if (k >= 5) chk("bp_no_regrant", 64'(req_ready[1]), 64'd0);
    end
    for (int k = 0; k < 8; k++) tick('1, '1, 1'b1);
    do_reset();
    tick('1, '1, 1'b1);
    tick('1, '1, 1'b1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick('0, '1, 1'b1);
      chk("rst_flight_quiet", 64'(rsp_valid), 64'd0);
    end
    tick('1, '1, 1'b1);
    chk("rst_first_winner", 64'(req_ready), 64'd1);
    do_reset();
    for (int k = 0; k < 400; k++) tick(N'($urandom), N'($urandom), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
